mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 111 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for an iterative radix-2/radix-4 multiplier.
// Tracks bits processed, issues the operand load pulse and flags completion.
module mul_seq_ctrl #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic             op_hold,
    input  logic             op_mode,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] counter,
    output logic             busy,
    output logic             done,
    output logic             load,
    output logic             step_en
);

    localparam logic [1:0]       S_IDLE = 2'b00;
    localparam logic [1:0]       S_EXEC = 2'b01;
    localparam logic [1:0]       S_DONE = 2'b10;
    localparam logic [CNT_W:0]   ITER_X = (CNT_W+1)'(ITER);
    localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_counter;
    logic             r_load;
    logic             r_mode;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_counter_nxt;
    logic             w_load_nxt;
    logic             w_mode_nxt;
    logic [CNT_W:0]   w_step;
    logic [CNT_W:0]   w_sum;

    // One extra bit on the sum so the end-of-operation compare never sees a wrapped value.
    assign w_step = r_mode ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
    assign w_sum  = {1'b0, r_counter} + w_step;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_load    <= 1'b0;
            r_mode    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_load    <= w_load_nxt;
            r_mode    <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_load_nxt    = 1'b0;
        w_mode_nxt    = r_mode;
        if (op_clear) begin
            w_state_nxt   = S_IDLE;
            w_counter_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_counter_nxt = '0;
                    if (op_start) begin
                        w_state_nxt = S_EXEC;
                        w_load_nxt  = 1'b1;
                        w_mode_nxt  = op_mode;
                    end
                end
                S_EXEC: begin
                    if (!op_hold) begin
                        if (w_sum >= ITER_X) begin
                            w_state_nxt   = S_DONE;
                            w_counter_nxt = ITER_C;
                        end else begin
                            w_counter_nxt = w_sum[CNT_W-1:0];
                        end
                    end
                end
                S_DONE: begin
                    if (op_start) begin
                        w_state_nxt   = S_EXEC;
                        w_counter_nxt = '0;
                        w_load_nxt    = 1'b1;
                        w_mode_nxt    = op_mode;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_counter_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy    = (r_state == S_EXEC);
        done    = (r_state == S_DONE);
        step_en = (r_state == S_EXEC) && !op_hold;
    end

    assign state   = r_state;
    assign counter = r_counter;
    assign load    = r_load;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: ITER=32 and ITER=31 instances share stimulus.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, op_start, op_clear, op_hold, op_mode;
    logic [1:0] st32, st31;
    logic [5:0] cnt32, cnt31;
    logic busy32, done32, load32, se32;
    logic busy31, done31, load31, se31;

    int n_tests = 0;
    int n_fail  = 0;
    int e, e_done32, e_done31, n_busy;

    mul_seq_ctrl #(.ITER(32), .CNT_W(6)) u32 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
        .op_hold(op_hold), .op_mode(op_mode), .state(st32), .counter(cnt32),
        .busy(busy32), .done(done32), .load(load32), .step_en(se32));

    mul_seq_ctrl #(.ITER(31), .CNT_W(6)) u31 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
        .op_hold(op_hold), .op_mode(op_mode), .state(st31), .counter(cnt31),
        .busy(busy31), .done(done31), .load(load31), .step_en(se31));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0; op_hold = 1'b0; op_mode = 1'b0;
        @(negedge clk);
        tick();
        check("rst_state", st32, 0);
        check("rst_counter", cnt32, 0);
        check("rst_flags", {busy32, done32, load32, se32}, 0);

        // Radix-2, ITER=32: accept edge is edge 1
        reset_n = 1'b1; op_start = 1'b1; op_mode = 1'b0;
        tick();
        op_start = 1'b0;
        check("r2_state_exec", st32, 1);
        check("r2_load", load32, 1);
        check("r2_cnt0", cnt32, 0);
        check("r2_step_en", se32, 1);
        e = 1; n_busy = busy32 ? 1 : 0;
        while (!done32 && e < 60) begin
            tick(); e++;
            if (busy32) n_busy++;
            if (e == 2) check("r2_load_once", load32, 0);
            if (!done32) check("r2_cnt_seq", cnt32, e - 1);
        end
        check("r2_done_edge", e, 33);
        check("r2_done_cnt", cnt32, 32);
        check("r2_busy_cycles", n_busy, 32);
        check("r2_done_state", st32, 2);

        tick();
        check("done_hold_cnt", cnt32, 32);
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check("clr_done_state", st32, 0);
        check("clr_done_cnt", cnt32, 0);

        // Radix-4 with op_mode toggled mid-operation
        op_start = 1'b1; op_mode = 1'b1;
        tick();
        op_start = 1'b0;
        e = 1; e_done32 = 0; e_done31 = 0;
        while ((e_done32 == 0 || e_done31 == 0) && e < 60) begin
            op_mode = ~op_mode;
            tick(); e++;
            if (done32 && e_done32 == 0) e_done32 = e;
            if (done31 && e_done31 == 0) e_done31 = e;
            if (!done32) check("r4_cnt_seq", cnt32, 2 * (e - 1));
        end
        check("r4_done_edge32", e_done32, 17);
        check("r4_done_cnt32", cnt32, 32);
        check("r4_done_edge31", e_done31, 17);
        check("r4_sat_cnt31", cnt31, 31);

        // Back-to-back restart from DONE, then a 5-cycle hold at counter=10
        op_start = 1'b1; op_mode = 1'b0;
        tick();
        op_start = 1'b0;
        check("restart_state", st32, 1);
        check("restart_load", load32, 1);
        check("restart_cnt", cnt32, 0);
        e = 1;
        repeat (10) begin tick(); e++; end
        check("hold_pre_cnt", cnt32, 10);
        op_hold = 1'b1;
        #1;
        check("hold_step_en", se32, 0);
        repeat (5) begin
            tick(); e++;
            check("hold_cnt", cnt32, 10);
            check("hold_step_en_cyc", se32, 0);
        end
        op_hold = 1'b0;
        while (!done32 && e < 80) begin tick(); e++; end
        check("hold_done_edge", e, 38);
        check("hold_done_cnt", cnt32, 32);

        // Clear mid-EXEC at counter=20 while also holding
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (20) tick();
        check("mid_cnt20", cnt32, 20);
        op_clear = 1'b1; op_hold = 1'b1;
        tick();
        op_clear = 1'b0; op_hold = 1'b0;
        check("clr_mid_state", st32, 0);
        check("clr_mid_cnt", cnt32, 0);

        // Start and clear together in IDLE
        op_start = 1'b1; op_clear = 1'b1;
        tick();
        op_start = 1'b0; op_clear = 1'b0;
        check("start_clr_state", st32, 0);
        check("start_clr_load", load32, 0);

        // First EXEC cycle held: load must still last only one cycle
        op_start = 1'b1; op_hold = 1'b1;
        tick();
        op_start = 1'b0;
        check("held_first_load", load32, 1);
        check("held_first_se", se32, 0);
        tick();
        check("held_second_load", load32, 0);
        check("held_second_cnt", cnt32, 0);
        op_hold = 1'b0;
        tick();
        check("held_resume_cnt", cnt32, 1);

        // Reset mid-operation at counter=15
        repeat (14) tick();
        check("pre_rst_cnt", cnt32, 15);
        reset_n = 1'b0; op_start = 1'b1; op_hold = 1'b1; op_clear = 1'b1;
        #1;
        check("rst_no_early", st32, 1);
        tick();
        check("rst_mid_state", st32, 0);
        check("rst_mid_cnt", cnt32, 0);
        check("rst_mid_flags", {busy32, done32, load32, se32}, 0);

        // Start accepted on the first edge after reset release
        reset_n = 1'b1; op_clear = 1'b0; op_hold = 1'b0; op_start = 1'b1;
        tick();
        op_start = 1'b0;
        check("post_rst_state", st32, 1);
        check("post_rst_load", load32, 1);

        // Illegal encoding recovers to IDLE
        force u32.r_state = 2'b11;
        #1;
        check("forced_state", st32, 3);
        release u32.r_state;
        tick();
        check("illegal_state", st32, 0);
        check("illegal_cnt", cnt32, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
